// File: rtl/ad7946_pkg.sv
// Shared types and frame constants for the AD7946 acquisition controller.
package ad7946_pkg;

  localparam int DATA_W     = 14;
  localparam int FRAME_BITS = 16;
  localparam int LEAD_ZEROS = FRAME_BITS - DATA_W;

  typedef enum logic [1:0] {
    ST_IDLE    = 2'd0,
    ST_CONVERT = 2'd1,
    ST_SHIFT   = 2'd2,
    ST_QUIET   = 2'd3
  } state_t;

endpackage

// File: rtl/ad7946_sclk_shifter.sv
// Serial clock generator and shift-in for one AD7946 read frame.
// A start pulse launches 16 sclk pulses (low phase first). sdi is sampled
// on the clk edge that raises sclk. The register is only DATA_W wide, so
// the two leading frame bits fall off the top and are never inspected.
// o_last flags the clk whose rising edge ends the final high phase.
module ad7946_sclk_shifter
  import ad7946_pkg::*;
#(
  parameter int SCLK_HALF = 2
) (
  input  logic              clk,
  input  logic              reset_n,
  input  logic              i_start,
  input  logic              i_sdi,
  output logic              o_sclk,
  output logic              o_last,
  output logic [DATA_W-1:0] o_shift_data
);

  localparam int HW = (SCLK_HALF > 1) ? $clog2(SCLK_HALF) : 1;
  localparam int BW = $clog2(FRAME_BITS);
  localparam logic [HW-1:0] HALF_LOAD = HW'(SCLK_HALF - 1);
  localparam logic [BW-1:0] LAST_BIT  = BW'(FRAME_BITS - 1);

  logic              r_active;
  logic              r_sclk;
  logic [HW-1:0]     r_half;
  logic [BW-1:0]     r_bit;
  logic [DATA_W-1:0] r_shift;

  assign o_sclk       = r_sclk;
  assign o_shift_data = r_shift;
  assign o_last       = r_active && r_sclk && (r_half == '0) && (r_bit == LAST_BIT);

  // Half-period timer, sclk phase toggling and sdi capture on rising sclk.
  always_ff @(posedge clk) begin
    if (!reset_n) begin
      r_active <= 1'b0;
      r_sclk   <= 1'b0;
      r_half   <= '0;
      r_bit    <= '0;
      r_shift  <= '0;
    end else if (i_start) begin
      r_active <= 1'b1;
      r_sclk   <= 1'b0;
      r_half   <= HALF_LOAD;
      r_bit    <= '0;
      r_shift  <= '0;
    end else if (r_active) begin
      if (r_half != '0) begin
        r_half <= r_half - HW'(1);
      end else if (!r_sclk) begin
        r_sclk  <= 1'b1;
        r_shift <= {r_shift[DATA_W-2:0], i_sdi};
        r_half  <= HALF_LOAD;
      end else begin
        r_sclk <= 1'b0;
        r_half <= HALF_LOAD;
        if (r_bit == LAST_BIT) begin
          r_active <= 1'b0;
        end else begin
          r_bit <= r_bit + BW'(1);
        end
      end
    end
  end

endmodule

// File: rtl/ad7946_adc_controller.sv
// AD7946 free-running acquisition controller: conversion timing, channel
// alternation and result registers. Serial clocking lives in the shifter.
// The clk that raises cs_n also carries data_valid; cs_n then stays high
// for QUIET_CYCLES more clks before the next conversion starts.
module ad7946_adc_controller
  import ad7946_pkg::*;
#(
  parameter int CONV_CYCLES  = 170,
  parameter int SCLK_HALF    = 2,
  parameter int QUIET_CYCLES = 10
) (
  input  logic              clk,
  input  logic              reset_n,
  input  logic              enable,
  output logic              pden,
  output logic              chsel,
  output logic              cs_n,
  output logic              sclk,
  input  logic              sdi,
  output logic [DATA_W-1:0] data,
  output logic              data_ch,
  output logic              data_valid
);

  localparam int CNT_MAX = (CONV_CYCLES > QUIET_CYCLES) ? CONV_CYCLES : QUIET_CYCLES;
  localparam int CW      = $clog2(CNT_MAX + 1);
  localparam logic [CW-1:0] CONV_LOAD  = CW'(CONV_CYCLES - 1);
  localparam logic [CW-1:0] QUIET_LOAD = CW'(QUIET_CYCLES);

  state_t            r_state;
  logic [CW-1:0]     r_cnt;
  logic              r_cs_n;
  logic              r_chsel;
  logic              r_frame_ch;
  logic [DATA_W-1:0] r_data;
  logic              r_data_ch;
  logic              r_data_valid;

  logic              w_start;
  logic              w_last;
  logic [DATA_W-1:0] w_shift_data;

  assign w_start = (r_state == ST_CONVERT) && (r_cnt == '0);

  ad7946_sclk_shifter #(
    .SCLK_HALF (SCLK_HALF)
  ) u_shifter (
    .clk          (clk),
    .reset_n      (reset_n),
    .i_start      (w_start),
    .i_sdi        (sdi),
    .o_sclk       (sclk),
    .o_last       (w_last),
    .o_shift_data (w_shift_data)
  );

  assign cs_n       = r_cs_n;
  assign chsel      = r_chsel;
  assign data       = r_data;
  assign data_ch    = r_data_ch;
  assign data_valid = r_data_valid;
  // Power-down is released as soon as acquisition is requested, and held
  // released until an in-flight frame has fully drained back to IDLE.
  assign pden       = !((enable && reset_n) || (r_state != ST_IDLE));

  // Frame sequencer: IDLE -> CONVERT -> SHIFT -> QUIET -> CONVERT/IDLE.
  always_ff @(posedge clk) begin
    if (!reset_n) begin
      r_state      <= ST_IDLE;
      r_cnt        <= '0;
      r_cs_n       <= 1'b1;
      r_chsel      <= 1'b0;
      r_frame_ch   <= 1'b0;
      r_data       <= '0;
      r_data_ch    <= 1'b0;
      r_data_valid <= 1'b0;
    end else begin
      r_data_valid <= 1'b0;
      case (r_state)
        ST_IDLE: begin
          if (enable) begin
            r_state    <= ST_CONVERT;
            r_cs_n     <= 1'b0;
            r_cnt      <= CONV_LOAD;
            r_frame_ch <= r_chsel;
          end
        end
        ST_CONVERT: begin
          if (r_cnt == '0) begin
            r_state <= ST_SHIFT;
          end else begin
            r_cnt <= r_cnt - CW'(1);
          end
        end
        ST_SHIFT: begin
          if (w_last) begin
            r_state      <= ST_QUIET;
            r_cs_n       <= 1'b1;
            r_cnt        <= QUIET_LOAD;
            r_data       <= w_shift_data;
            r_data_ch    <= r_frame_ch;
            r_data_valid <= 1'b1;
            r_chsel      <= ~r_chsel;
          end
        end
        ST_QUIET: begin
          if (r_cnt != '0) begin
            r_cnt <= r_cnt - CW'(1);
          end else if (enable) begin
            r_state    <= ST_CONVERT;
            r_cs_n     <= 1'b0;
            r_cnt      <= CONV_LOAD;
            r_frame_ch <= r_chsel;
          end else begin
            r_state <= ST_IDLE;
          end
        end
        default: r_state <= ST_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_ad7946_adc_controller.sv
// Bench for ad7946_adc_controller: behavioural ADC model on sdi, expected
// results queued by the stimulus, popped by a monitor on data_valid.
module tb_ad7946_adc_controller;

  localparam int CONV   = 170;
  localparam int SH     = 2;
  localparam int QUIET  = 10;
  localparam int LOW_W  = CONV + 32 * SH;
  localparam int PERIOD = 1 + CONV + 32 * SH + QUIET;

  logic        clk = 1'b0;
  logic        reset_n;
  logic        enable;
  logic        sdi;
  logic        pden, chsel, cs_n, sclk, data_ch, data_valid;
  logic [13:0] data;

  always #5 clk = ~clk;

  ad7946_adc_controller #(
    .CONV_CYCLES  (CONV),
    .SCLK_HALF    (SH),
    .QUIET_CYCLES (QUIET)
  ) dut (
    .clk        (clk),
    .reset_n    (reset_n),
    .enable     (enable),
    .pden       (pden),
    .chsel      (chsel),
    .cs_n       (cs_n),
    .sclk       (sclk),
    .sdi        (sdi),
    .data       (data),
    .data_ch    (data_ch),
    .data_valid (data_valid)
  );

  int checks = 0;
  int errors = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  // ADC model: frame = lead bits + 14-bit code, MSB first; first bit
  // presented at cs_n fall, next bit after each sclk falling edge.
  logic [13:0] code0, code1;
  logic [1:0]  lead;
  logic [15:0] mframe;
  int          midx;

  always @(negedge cs_n) begin
    mframe = {lead, (chsel ? code1 : code0)};
    midx   = 0;
    sdi    = mframe[15];
  end

  always @(negedge sclk) begin
    if (!cs_n) begin
      midx++;
      if (midx < 16) sdi = mframe[15 - midx];
    end
  end

  // Scoreboard.
  typedef struct {
    logic [13:0] d;
    logic        ch;
  } exp_t;
  exp_t q[$];

  task automatic push(input logic [13:0] d, input logic ch);
    exp_t e;
    e.d  = d;
    e.ch = ch;
    q.push_back(e);
  endtask

  logic prev_dv = 1'b0;
  always @(negedge clk) begin
    exp_t e;
    if (prev_dv) chk("dv_width", {31'd0, data_valid}, 32'd0);
    if (data_valid === 1'b1) begin
      if (q.size() == 0) begin
        checks++;
        errors++;
        $display("FAIL unexpected_valid: got data=0x%0h ch=%0d expected no pulse at %0t",
                 data, data_ch, $time);
      end else begin
        e = q.pop_front();
        chk("result_data", {18'd0, data}, {18'd0, e.d});
        chk("result_ch", {31'd0, data_ch}, {31'd0, e.ch});
      end
    end
    prev_dv = data_valid;
  end

  // Frame timing measurement.
  logic meas_en = 1'b0;
  int   cyc = 0, last_fall = 0, sclk_cnt = 0, n_period = 0, n_width = 0;
  logic have_fall = 1'b0, prev_cs = 1'b1, prev_sclk = 1'b0;
  always @(negedge clk) begin
    cyc++;
    if (prev_cs && !cs_n) begin
      if (have_fall && meas_en) begin
        chk("frame_period", cyc - last_fall, PERIOD);
        n_period++;
      end
      last_fall = cyc;
      have_fall = 1'b1;
      sclk_cnt  = 0;
    end
    if (!prev_cs && cs_n && meas_en) begin
      chk("cs_low_width", cyc - last_fall, LOW_W);
      chk("sclk_pulses", sclk_cnt, 16);
      n_width++;
    end
    if (!prev_sclk && sclk) sclk_cnt++;
    prev_cs   = cs_n;
    prev_sclk = sclk;
  end

  task automatic wait_empty(input int max, input string name);
    int n = 0;
    while (q.size() != 0 && n < max) begin
      @(negedge clk);
      n++;
    end
    chk(name, q.size(), 0);
    q.delete();
  endtask

  initial begin
    repeat (20000) @(posedge clk);
    $display("FAIL watchdog: simulation exceeded cycle budget");
    $fatal(1);
  end

  initial begin
    int n;
    int lows;
    reset_n = 1'b0;
    enable  = 1'b0;
    sdi     = 1'b0;
    code0   = '0;
    code1   = '0;
    lead    = 2'b00;

    repeat (3) @(negedge clk);
    chk("rst_cs_n", cs_n, 1);
    chk("rst_sclk", sclk, 0);
    chk("rst_pden", pden, 1);
    chk("rst_chsel", chsel, 0);
    chk("rst_data", data, 0);
    chk("rst_data_ch", data_ch, 0);
    chk("rst_dv", data_valid, 0);
    reset_n = 1'b1;
    repeat (5) @(negedge clk);
    chk("idle_cs_n", cs_n, 1);
    chk("idle_pden", pden, 1);

    // Free-running alternation with timing measurement.
    code0 = 14'h2A5B;
    code1 = 14'h15A4;
    push(14'h2A5B, 1'b0);
    push(14'h15A4, 1'b1);
    push(14'h2A5B, 1'b0);
    push(14'h15A4, 1'b1);
    meas_en = 1'b1;
    enable  = 1'b1;
    @(negedge clk);
    chk("start_cs_n", cs_n, 0);
    chk("start_pden", pden, 0);
    wait_empty(4 * PERIOD + 100, "alt_timeout");
    @(negedge clk);
    meas_en = 1'b0;
    enable  = 1'b0;
    repeat (20) @(negedge clk);
    chk("alt_idle_cs_n", cs_n, 1);
    chk("alt_idle_pden", pden, 1);
    chk("alt_chsel", chsel, 0);
    chk("n_period", n_period, 3);
    chk("n_width", n_width, 4);

    // Boundary codes.
    code0 = 14'h0000;
    code1 = 14'h3FFF;
    push(14'h0000, 1'b0);
    push(14'h3FFF, 1'b1);
    enable = 1'b1;
    wait_empty(2 * PERIOD + 100, "bound_timeout");
    @(negedge clk);
    enable = 1'b0;
    repeat (20) @(negedge clk);

    // Non-zero leading bits, enable dropped mid-SHIFT.
    code0 = 14'h1234;
    code1 = 14'h0ABC;
    lead  = 2'b11;
    push(14'h1234, 1'b0);
    enable = 1'b1;
    n = 0;
    while (sclk !== 1'b1 && n < 400) begin
      @(negedge clk);
      n++;
    end
    chk("sclk_seen", sclk, 1);
    enable = 1'b0;
    wait_empty(PERIOD, "drop_timeout");
    repeat (30) @(negedge clk);
    chk("drop_cs_n", cs_n, 1);
    chk("drop_pden", pden, 1);
    chk("drop_sclk", sclk, 0);
    chk("drop_chsel", chsel, 1);
    lows = 0;
    repeat (PERIOD + 20) begin
      @(negedge clk);
      if (cs_n !== 1'b1) lows++;
    end
    chk("drop_stays_idle", lows, 0);
    lead = 2'b00;

    // Reset during CONVERT of a CH1 frame.
    code0 = 14'h0F0F;
    code1 = 14'h3333;
    enable = 1'b1;
    n = 0;
    while (cs_n !== 1'b0 && n < 50) begin
      @(negedge clk);
      n++;
    end
    chk("conv_cs_low", cs_n, 0);
    repeat (20) @(negedge clk);
    chk("pre_rst_chsel", chsel, 1);
    reset_n = 1'b0;
    @(negedge clk);
    chk("abort_cs_n", cs_n, 1);
    chk("abort_sclk", sclk, 0);
    chk("abort_dv", data_valid, 0);
    chk("abort_chsel", chsel, 0);
    chk("abort_data", data, 0);
    chk("abort_pden", pden, 1);
    repeat (3) @(negedge clk);
    push(14'h0F0F, 1'b0);
    reset_n = 1'b1;
    wait_empty(PERIOD + 50, "post_rst_timeout");
    @(negedge clk);
    enable = 1'b0;
    repeat (20) @(negedge clk);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
